// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle for multicycle_ctrl.
//   imem_req   : instruction fetch request (controller -> imem)
//   imem_ready : instruction word valid this cycle (imem -> controller)
//   dmem_req   : data read request (controller -> dmem)
//   dmem_ready : data read complete this cycle (dmem -> controller)
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (output imem_req, output dmem_req,
                  input  imem_ready, input dmem_ready);
  modport slave  (input  imem_req, input dmem_req,
                  output imem_ready, output dmem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC|MEM/WB sequencer for the 8-bit datapath.
// Decodes Instr[15:11], drives datapath controls plus PC/IR write strobes,
// supervises memory waits with a timeout and halts on HALT or a fault.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   mem              imem/dmem handshake (multicycle_ctrl_if.master)
//   Instr[15:0]      IR contents, stable after IRWrite
//   ALUFlags[3:0]    {N,Z,C,V}, sampled in EXEC
//   IRWrite/PCWrite  one-cycle load strobes
//   PCSrc            0 = PC+4, 1 = Instr[7:0]
//   RegWrite(2)      register write strobes (2 = MUL high byte)
//   ALUSrc/ALUControl/LM/ImmSrc/LI  decode controls, held DECODE..WB
//   halted, fault    sticky status
// Optional macro MULTICYCLE_CTRL_PERF_EN adds retired[CNT_W-1:0] (PCWrite
// count, wrapping) and stall[CNT_W-1:0] (ready-low wait cycles, saturating).
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   mem,
  input  logic [15:0]         Instr,
  input  logic [3:0]          ALUFlags,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                RegWrite2,
  output logic                ALUSrc,
  output logic [4:0]          ALUControl,
  output logic                LM,
  output logic                ImmSrc,
  output logic                LI,
  output logic                halted,
  output logic                fault
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    retired,
  output logic [CNT_W-1:0]    stall
`endif
);

  localparam logic [4:0] OP_ALU_MAX = 5'h17;
  localparam logic [4:0] OP_ADDI    = 5'h18;
  localparam logic [4:0] OP_LI      = 5'h19;
  localparam logic [4:0] OP_LM      = 5'h1A;
  localparam logic [4:0] OP_B       = 5'h1B;
  localparam logic [4:0] OP_BZ      = 5'h1C;
  localparam logic [4:0] OP_MUL     = 5'h1D;
  localparam logic [4:0] OP_HALT    = 5'h1F;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             fault_q, fault_d;
  logic             zflag_q, zflag_d;
  logic             timeout;

  logic [4:0] op;
  logic       d_alusrc, d_lm, d_imm, d_li, d_rw, d_rw2;
  logic [4:0] d_aluctl;
  logic       dec_en;

  assign op = Instr[15:11];

  // Operand fields and the other flags belong to the datapath.
  logic unused_bits;
  assign unused_bits = ^{Instr[10:0], ALUFlags[3], ALUFlags[1:0]};

  // Opcode decode table; only exposed on the ports from DECODE through WB.
  always_comb begin
    d_alusrc = 1'b0;
    d_aluctl = '0;
    d_lm     = 1'b0;
    d_imm    = 1'b0;
    d_li     = 1'b0;
    d_rw     = 1'b0;
    d_rw2    = 1'b0;
    if (op <= OP_ALU_MAX) begin
      d_aluctl = op;
      d_rw     = 1'b1;
    end else begin
      case (op)
        OP_ADDI: begin d_alusrc = 1'b1; d_rw = 1'b1; end
        OP_LI:   begin
          d_li = 1'b1; d_alusrc = 1'b1; d_imm = 1'b1;
          d_aluctl = 5'h17; d_rw = 1'b1;
        end
        OP_LM:   begin d_lm = 1'b1; d_rw = 1'b1; end
        OP_MUL:  begin d_aluctl = 5'h1D; d_rw = 1'b1; d_rw2 = 1'b1; end
        default: ;
      endcase
    end
  end

  // Saturating wait counter; the cycle in which it reaches MEM_TIMEOUT with
  // ready still low is the last permitted wait cycle.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc >= CNT_W'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
      zflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      zflag_q <= zflag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    zflag_d = zflag_q;
    case (state_q)
      S_FETCH: begin
        if (mem.imem_ready) state_d = S_DECODE;
        else begin
          cnt_d = cnt_inc;
          if (timeout) begin fault_d = 1'b1; state_d = S_HALT; end
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (op == OP_HALT)    state_d = S_HALT;
        else if (op == OP_LM) state_d = S_MEM;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        zflag_d = ALUFlags[2];
        state_d = S_WB;
      end
      S_MEM: begin
        if (mem.dmem_ready) state_d = S_WB;
        else begin
          cnt_d = cnt_inc;
          if (timeout) begin fault_d = 1'b1; state_d = S_HALT; end
        end
      end
      S_WB: begin
        // Clear here too so MEM waits never eat into the next fetch budget.
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output logic; reset forces every output low in the cycles it is held.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    RegWrite     = 1'b0;
    RegWrite2    = 1'b0;
    ALUSrc       = 1'b0;
    ALUControl   = '0;
    LM           = 1'b0;
    ImmSrc       = 1'b0;
    LI           = 1'b0;
    halted       = 1'b0;
    fault        = fault_q;
    dec_en       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        IRWrite      = mem.imem_ready;
      end
      S_DECODE, S_EXEC: dec_en = 1'b1;
      S_MEM: begin
        dec_en       = 1'b1;
        mem.dmem_req = 1'b1;
      end
      S_WB: begin
        dec_en    = 1'b1;
        PCWrite   = 1'b1;
        PCSrc     = (op == OP_B) || ((op == OP_BZ) && zflag_q);
        RegWrite  = d_rw;
        RegWrite2 = d_rw2;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (dec_en) begin
      ALUSrc     = d_alusrc;
      ALUControl = d_aluctl;
      LM         = d_lm;
      ImmSrc     = d_imm;
      LI         = d_li;
    end
    if (reset) begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      PCSrc        = 1'b0;
      RegWrite     = 1'b0;
      RegWrite2    = 1'b0;
      ALUSrc       = 1'b0;
      ALUControl   = '0;
      LM           = 1'b0;
      ImmSrc       = 1'b0;
      LI           = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, stall_q;
  logic             stall_cyc;

  assign stall_cyc = ((state_q == S_FETCH) && !mem.imem_ready) ||
                     ((state_q == S_MEM)   && !mem.dmem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (PCWrite)                retired_q <= retired_q + CNT_W'(1);
      if (stall_cyc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
  assign stall   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: opcode table, multi-cycle corner
// sequences (timeouts, ready-wins, HALT, reset mid-MEM) and a randomized
// instruction stream checked against a cycle-count model of the sequencer.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        IRWrite, PCWrite, PCSrc, RegWrite, RegWrite2, ALUSrc;
  logic [4:0]  ALUControl;
  logic        LM, ImmSrc, LI, halted, fault;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [7:0]  retired, stall;
`endif

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem(mif), .Instr(Instr), .ALUFlags(ALUFlags),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .RegWrite2(RegWrite2), .ALUSrc(ALUSrc), .ALUControl(ALUControl), .LM(LM),
    .ImmSrc(ImmSrc), .LI(LI), .halted(halted), .fault(fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .retired(retired), .stall(stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl_o();
    return {ALUSrc, ALUControl, LM, ImmSrc, LI};
  endfunction

  function automatic logic [17:0] all_o();
    return {mif.imem_req, mif.dmem_req, IRWrite, PCWrite, PCSrc, RegWrite,
            RegWrite2, ctl_o(), halted, fault};
  endfunction

  // Reference decode: {ALUSrc, ALUControl, LM, ImmSrc, LI} from opcode rules.
  function automatic logic [8:0] m_ctl(input logic [4:0] op);
    if (op <= 5'd23) return {1'b0, op, 3'b000};
    case (op)
      5'd24:   return {1'b1, 5'd0,  3'b000};
      5'd25:   return {1'b1, 5'd23, 3'b011};
      5'd26:   return {1'b0, 5'd0,  3'b100};
      5'd29:   return {1'b0, 5'd29, 3'b000};
      default: return 9'd0;
    endcase
  endfunction

  // Held in reset for two cycles; returns at a negedge with reset released.
  task automatic do_reset();
    reset = 1'b1;
    mif.imem_ready = 1'($urandom);
    mif.dmem_ready = 1'($urandom);
    #1 chk("reset_outputs", all_o(), 0);
    @(negedge clk);
    #1 chk("reset_outputs_held", all_o(), 0);
    @(negedge clk);
    reset = 1'b0;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
  endtask

  // Runs one instruction starting in FETCH: wi imem wait cycles, wd dmem waits.
  task automatic run_instr(input logic [15:0] ins, input logic [3:0] flg,
                           input int wi, input int wd, input logic [8:0] e_ctl,
                           input logic e_rw, input logic e_rw2, input logic e_pcs);
    logic [4:0] op;
    op = ins[15:11];
    for (int i = 0; i < wi; i++) begin
      mif.imem_ready = 1'b0; mif.dmem_ready = 1'($urandom); ALUFlags = 4'($urandom);
      #1 chk("fetch_wait", {mif.imem_req, IRWrite, PCWrite}, 3'b100);
      @(negedge clk);
    end
    mif.imem_ready = 1'b1; Instr = ins;
    #1 chk("fetch_irwrite", {mif.imem_req, IRWrite, PCWrite}, 3'b110);
    chk("fetch_ctl", ctl_o(), 0);
    @(negedge clk);
    mif.imem_ready = 1'($urandom); mif.dmem_ready = 1'($urandom);
    #1 chk("decode_ctl", ctl_o(), e_ctl);
    chk("decode_strobes", {mif.imem_req, IRWrite, PCWrite, RegWrite}, 0);
    @(negedge clk);
    if (op == 5'h1F) begin
      mif.imem_ready = 1'($urandom);
      #1 chk("halt_state", {halted, PCWrite, mif.imem_req}, 3'b100);
      @(negedge clk);
      return;
    end
    if (op == 5'h1A) begin
      for (int i = 0; i <= wd; i++) begin
        mif.dmem_ready = (i == wd); mif.imem_ready = 1'($urandom);
        #1 chk("mem_req", {mif.dmem_req, mif.imem_req, RegWrite}, 3'b100);
        chk("mem_ctl", ctl_o(), e_ctl);
        @(negedge clk);
      end
    end else begin
      ALUFlags = flg; mif.imem_ready = 1'($urandom); mif.dmem_ready = 1'($urandom);
      #1 chk("exec_ctl", ctl_o(), e_ctl);
      chk("exec_strobes", {PCWrite, RegWrite, RegWrite2, mif.dmem_req}, 0);
      @(negedge clk);
    end
    ALUFlags = ~flg;  // WB must use the flag latched in EXEC
    mif.imem_ready = 1'($urandom); mif.dmem_ready = 1'($urandom);
    #1 chk("wb_pcwrite", {PCWrite, mif.imem_req}, 2'b10);
    chk("wb_pcsrc", PCSrc, e_pcs);
    chk("wb_regwrite", {RegWrite, RegWrite2}, {e_rw, e_rw2});
    chk("wb_ctl", ctl_o(), e_ctl);
    @(negedge clk);
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  flg;
    int          wi;
    int          wd;
    logic [8:0]  ctl;
    logic        rw;
    logic        rw2;
    logic        pcs;
  } vec_t;

  vec_t tbl [12];

  int   exp_ret;
  int   exp_stall;

  initial begin
    tbl[0]  = '{16'h0000, 4'h0, 0, 0, 9'h000, 1'b1, 1'b0, 1'b0};  // ADD
    tbl[1]  = '{16'h2B45, 4'h0, 2, 0, 9'h028, 1'b1, 1'b0, 1'b0};  // ALU op 5
    tbl[2]  = '{16'hB800, 4'hF, 0, 0, 9'h0B8, 1'b1, 1'b0, 1'b0};  // ALU op 0x17
    tbl[3]  = '{16'hC105, 4'h0, 0, 0, 9'h100, 1'b1, 1'b0, 1'b0};  // ADDI
    tbl[4]  = '{16'hCB2A, 4'h0, 0, 0, 9'h1BB, 1'b1, 1'b0, 1'b0};  // LI
    tbl[5]  = '{16'hD012, 4'h0, 0, 3, 9'h004, 1'b1, 1'b0, 1'b0};  // LM, 3 waits
    tbl[6]  = '{16'hD840, 4'h0, 0, 0, 9'h000, 1'b0, 1'b0, 1'b1};  // B
    tbl[7]  = '{16'hE040, 4'h4, 0, 0, 9'h000, 1'b0, 1'b0, 1'b1};  // BZ taken
    tbl[8]  = '{16'hE040, 4'h0, 0, 0, 9'h000, 1'b0, 1'b0, 1'b0};  // BZ not taken
    tbl[9]  = '{16'hE040, 4'hB, 1, 0, 9'h000, 1'b0, 1'b0, 1'b0};  // BZ, other flags set
    tbl[10] = '{16'hE800, 4'h0, 0, 0, 9'h0E8, 1'b1, 1'b1, 1'b0};  // MUL
    tbl[11] = '{16'hF000, 4'h0, 1, 0, 9'h000, 1'b0, 1'b0, 1'b0};  // NOP

    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++)
      run_instr(tbl[i].ins, tbl[i].flg, tbl[i].wi, tbl[i].wd,
                tbl[i].ctl, tbl[i].rw, tbl[i].rw2, tbl[i].pcs);

    // Fetch timeout: 16 ready-low cycles, then sticky fault + halt.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mif.imem_ready = 1'b0; mif.dmem_ready = 1'($urandom);
      #1 chk("fetch_to_wait", {mif.imem_req, fault, halted}, 3'b100);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
      #1 chk("fetch_to_fault", {fault, halted, mif.imem_req, IRWrite, PCWrite}, 5'b11000);
      @(negedge clk);
    end
    do_reset();
    #1 chk("fault_cleared", {fault, halted, mif.imem_req}, 3'b001);

    // Ready on the 16th wait cycle wins over the timeout.
    run_instr(16'hF000, 4'h0, 15, 0, 9'h000, 1'b0, 1'b0, 1'b0);
    #1 chk("ready_wins_nofault", {fault, halted, mif.imem_req}, 3'b001);

    // MEM timeout on an LM that never gets dmem_ready.
    mif.imem_ready = 1'b1; Instr = 16'hD000;
    @(negedge clk);
    mif.imem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      mif.dmem_ready = 1'b0;
      #1 chk("mem_to_wait", {mif.dmem_req, LM, fault}, 3'b110);
      @(negedge clk);
    end
    mif.dmem_ready = 1'b1;
    #1 chk("mem_to_fault", {fault, halted, mif.dmem_req, PCWrite, RegWrite}, 5'b11000);

    // HALT opcode: absorbing, no PCWrite, no fault.
    @(negedge clk);
    do_reset();
    run_instr(16'hF800, 4'h0, 0, 0, 9'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mif.imem_ready = 1'($urandom); mif.dmem_ready = 1'($urandom);
      #1 chk("halt_absorb", {halted, fault, PCWrite, mif.imem_req, IRWrite}, 5'b10000);
      @(negedge clk);
    end

    // Reset asserted during MEM of an LM abandons it.
    do_reset();
    mif.imem_ready = 1'b1; Instr = 16'hD0AA;
    @(negedge clk);
    mif.imem_ready = 1'b0;
    @(negedge clk);
    mif.dmem_ready = 1'b0;
    #1 chk("pre_reset_mem", {mif.dmem_req, LM}, 2'b11);
    reset = 1'b1;
    #1 chk("reset_in_mem", all_o(), 0);
    @(negedge clk);
    #1 chk("reset_in_mem_held", all_o(), 0);
    reset = 1'b0;
    #1 chk("after_reset_fetch", {mif.imem_req, mif.dmem_req, LM}, 3'b100);
    run_instr(16'h0000, 4'h0, 0, 0, 9'h000, 1'b1, 1'b0, 1'b0);

    // Randomized instruction stream against the reference model.
    do_reset();
    exp_ret = 0;
    exp_stall = 0;
    for (int n = 0; n < 200; n++) begin
      logic [4:0]  op;
      logic [15:0] ins;
      logic [3:0]  flg;
      int          wi, wd;
      op  = 5'($urandom_range(0, 30));
      ins = {op, 11'($urandom)};
      flg = 4'($urandom);
      wi  = $urandom_range(0, 3);
      wd  = $urandom_range(0, 3);
      run_instr(ins, flg, wi, wd, m_ctl(op),
                (op <= 5'd26) || (op == 5'd29), op == 5'd29,
                (op == 5'd27) || ((op == 5'd28) && flg[2]));
      exp_ret++;
      exp_stall += wi + ((op == 5'd26) ? wd : 0);
    end
    #1 chk("random_no_fault", {fault, halted}, 2'b00);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_retired", retired, exp_ret % 256);
    chk("perf_stall", stall, (exp_stall > 255) ? 255 : exp_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the 8-bit processor datapath. It fetches 16-bit instructions over an imem handshake and decodes Instr[15:11]. It steps the datapath through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control inputs (RegWrite, RegWrite2, ALUSrc, ALUControl, PCSrc, LM, ImmSrc, LI), plus PC and IR write enables. It also supervises data-memory waits with a timeout and halts on a HALT opcode or a memory fault.

Parameters:
MEM_TIMEOUT, 16, maximum cycles spent waiting for imem_ready or dmem_ready before a fault (1..255).
CNT_W, 8, counter width for the wait counter and the optional retire counter.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high
Instr  input  16  current instruction from datapath IR, stable after IRWrite
ALUFlags  input  4  {N,Z,C,V} from ALU, valid in EXEC
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data read complete this cycle
imem_req  output  1  instruction fetch request
dmem_req  output  1  data read request
IRWrite  output  1  one-cycle load strobe for IR
PCWrite  output  1  one-cycle PC update strobe
PCSrc  output  1  0 = PC+4, 1 = Instr[7:0]
RegWrite  output  1  primary register write strobe
RegWrite2  output  1  second write port strobe (MUL high byte)
ALUSrc  output  1  0 = register, 1 = extended immediate
ALUControl  output  5  ALU operation
LM  output  1  select memory result / Instr[7:0] address
ImmSrc  output  1  0 = 3-bit imm, 1 = 8-bit imm
LI  output  1  destination = Instr[10:8]
halted  output  1  sticky, core stopped
fault  output  1  sticky, memory timeout occurred

Behaviour:
- Reset: state=FETCH, wait counter=0, all strobes/requests/ALU controls=0, halted=0, fault=0. Reset mid-instruction abandons it; imem_req/dmem_req low in the cycle after reset is sampled.
- Opcode map (Instr[15:11]):
  - 0x00-0x17: ALU reg-reg, ALUControl=opcode, ALUSrc=0.
  - 0x18 ADDI: ALUControl=0x00, ALUSrc=1, ImmSrc=0.
  - 0x19 LI: LI=1, ALUSrc=1, ImmSrc=1, ALUControl=0x17 (pass B).
  - 0x1A LM: LM=1.
  - 0x1B B: unconditional branch.
  - 0x1C BZ: branch if ALUFlags[2].
  - 0x1D MUL: ALUControl=0x1D, RegWrite and RegWrite2.
  - 0x1E NOP.
  - 0x1F HALT.
- FETCH: imem_req=1. On imem_ready, IRWrite=1 for that cycle and go to DECODE. Otherwise increment the wait counter. When the counter reaches MEM_TIMEOUT, set fault and go to HALT.
- DECODE: one cycle, decode outputs valid. Clear the wait counter. HALT goes to the HALT state; LM goes to MEM; all other opcodes go to EXEC.
- EXEC: one cycle, ALU controls held. Branch decision is latched from ALUFlags at the end of this cycle. Go to WB.
- MEM: dmem_req=1, LM=1. On dmem_ready go to WB. Otherwise the wait counter applies as in FETCH, with timeout -> fault and HALT.
- WB (one cycle):
  - PCWrite=1.
  - PCSrc=1 only for B, or for BZ with the latched Z=1.
  - RegWrite=1 for ALU/ADDI/LI/LM/MUL; RegWrite2=1 only for MUL.
  - Decode controls are held stable through WB.
  - Next state FETCH.
- HALT: absorbing state, halted=1, all strobes 0, ignores handshakes; only reset exits.
- Latency with zero-wait memory:
  - ALU, branch and NOP: 4 cycles.
  - LM: 4 cycles plus dmem wait cycles (MEM replaces EXEC).
- Each instruction produces exactly one PCWrite pulse; the PCWrite count equals instructions retired.
- imem_ready/dmem_ready outside their wait states are ignored. A ready arriving in the same cycle the counter hits MEM_TIMEOUT wins; no fault is raised.
- The wait counter saturates and never wraps.

Optional Feature:
Macro MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output retired[CNT_W-1:0], reset 0, incremented on every PCWrite, wrapping modulo 2^CNT_W. Adds output stall[CNT_W-1:0], counting cycles in FETCH/MEM with ready low, saturating at all-ones.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- ADD (0x00), imem_ready held 1 -> IRWrite in cycle 1, RegWrite=1 and PCWrite=1 with PCSrc=0 in cycle 4, then imem_req again in cycle 5.
- LI Instr=0xCB2A, ready immediate -> LI=1, ImmSrc=1, ALUSrc=1, ALUControl=0x17, RegWrite only in WB.
- BZ Instr=0xE040 with ALUFlags=4'b0100 -> PCSrc=1 in WB. Repeat with ALUFlags=0 -> PCSrc=0.
- LM with dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, LM=1 throughout, RegWrite in the following WB.
- imem_ready held low, MEM_TIMEOUT=16 -> fault=1 and halted=1 after 16 wait cycles; reset -> both 0 and imem_req back to 1.
- HALT 0xF800 -> halted=1 permanently, no PCWrite. Assert reset during MEM of an LM -> outputs 0, state FETCH.
